fresh_range_engine: RTL and testbench

Single-clock successor to the FIFO-fed fresh-ingredient bitmap. It accepts fresh/spoiled ID ranges over a valid/ready stream and buffers them in an internal FIFO. A word-wide writer fills or clears up to WORD_W bitmap bits per cycle. Point lookups are answered from the same bitmap, and the block clears the bitmap itself on reset and on command.

---
 rtl/fresh_range_engine.sv | 196 +++++++++++++++++++
 tb/tb_fresh_range_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fresh_range_engine.sv
// Range-driven fresh/spoiled bitmap: a FIFO of ID ranges feeds a word-wide writer
// that fills, clears and sweeps an inferred dual-port RAM, answering point lookups.
module fresh_range_engine #(
    parameter int ADDR_W     = 17,
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rng_valid,
    output logic              rng_ready,
    input  logic [ADDR_W-1:0] rng_low,
    input  logic [ADDR_W-1:0] rng_high,
    input  logic              rng_fresh,
    input  logic              clr_req,
    input  logic              chk_valid,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_ready,
    output logic              out_valid,
    output logic              out_fresh,
    output logic              busy,
    output logic              err_inverted,
    output logic [15:0]       ranges_done,
    output logic [1:0]        dbg_state
);
    localparam int OFF_W  = $clog2(WORD_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int NWORDS = 1 << IDX_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = 2 * ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // ready never depends on valid, and valid may be raised or dropped at any cycle.

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [WORD_W-1:0] bitmap   [NWORDS];
    logic [WORD_W-1:0] rd_word_q;

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, end_q, end_d;
    logic              fresh_q, fresh_d;
    logic              clr_pend_q, clr_pend_d;
    logic              err_q, err_d;
    logic [15:0]       done_q, done_d;
    logic              out_valid_q, out_valid_d;
    logic              has_res_q, has_res_d;
    logic [OFF_W-1:0]  rd_off_q, rd_off_d;

    logic              fifo_empty, fifo_full, push, pop, chk_fire, start_clear;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_low, head_high;
    logic              head_fresh;
    logic [IDX_W-1:0]  cur_idx;
    logic              end_word;
    logic [OFF_W-1:0]  hi_off;
    logic [WORD_W-1:0] lo_mask, hi_mask;
    logic              we;
    logic [WORD_W-1:0] wmask, wdata;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rng_ready  = !fifo_full;
    assign push       = rng_valid && rng_ready;

    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_low   = head[ADDR_W-1:0];
    assign head_high  = head[2*ADDR_W-1:ADDR_W];
    assign head_fresh = head[ENT_W-1];

    assign chk_ready  = (state_q == S_IDLE) && fifo_empty && !clr_pend_q;
    assign chk_fire   = chk_valid && chk_ready;
    assign busy       = (state_q != S_IDLE) || !fifo_empty || clr_pend_q;

    // End test is word-index equality, so a range ending at the top ID never wraps cur.
    assign cur_idx  = cur_q[ADDR_W-1:OFF_W];
    assign end_word = (cur_idx == end_q[ADDR_W-1:OFF_W]);
    assign hi_off   = end_word ? end_q[OFF_W-1:0] : {OFF_W{1'b1}};
    assign lo_mask  = {WORD_W{1'b1}} << cur_q[OFF_W-1:0];
    assign hi_mask  = {WORD_W{1'b1}} >> (~hi_off);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        end_d       = end_q;
        fresh_d     = fresh_q;
        err_d       = err_q;
        done_d      = done_q;
        pop         = 1'b0;
        start_clear = 1'b0;
        we          = 1'b0;
        wmask       = '0;
        wdata       = '0;
        case (state_q)
            S_IDLE: begin
                if (clr_pend_q) begin
                    start_clear = 1'b1;
                    state_d     = S_CLEAR;
                    cur_d       = '0;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_low > head_high) begin
                        err_d = 1'b1;
                    end else begin
                        cur_d   = head_low;
                        end_d   = head_high;
                        fresh_d = head_fresh;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                we    = 1'b1;
                wmask = lo_mask & hi_mask;
                wdata = {WORD_W{fresh_q}};
                if (end_word) begin
                    done_d  = done_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    cur_d = {cur_idx + IDX_W'(1), {OFF_W{1'b0}}};
                end
            end
            S_CLEAR: begin
                we    = 1'b1;
                wmask = {WORD_W{1'b1}};
                if (cur_idx == {IDX_W{1'b1}}) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end else begin
                    cur_d = {cur_idx + IDX_W'(1), {OFF_W{1'b0}}};
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request arriving during a sweep is absorbed by that sweep.
        clr_pend_d  = start_clear ? 1'b0 : (clr_pend_q || (clr_req && state_q != S_CLEAR));
        wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
        out_valid_d = chk_fire;
        has_res_d   = has_res_q || chk_fire;
        rd_off_d    = chk_fire ? chk_addr[OFF_W-1:0] : rd_off_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_CLEAR;
            cur_q       <= '0;
            end_q       <= '0;
            fresh_q     <= 1'b0;
            clr_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            has_res_q   <= 1'b0;
            rd_off_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            fresh_q     <= fresh_d;
            clr_pend_q  <= clr_pend_d;
            err_q       <= err_d;
            done_q      <= done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            has_res_q   <= has_res_d;
            rd_off_q    <= rd_off_d;
        end
    end

    // Storage arrays carry no reset: the sweep after reset initialises the bitmap.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {rng_fresh, rng_high, rng_low};
        if (we) begin
            for (int i = 0; i < WORD_W; i++) begin
                if (wmask[i]) bitmap[cur_idx][i] <= wdata[i];
            end
        end
        if (chk_fire) rd_word_q <= bitmap[chk_addr[ADDR_W-1:OFF_W]];
    end

    assign out_valid    = out_valid_q;
    assign out_fresh    = has_res_q && rd_word_q[rd_off_q];
    assign err_inverted = err_q;
    assign ranges_done  = done_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_fresh_range_engine.sv
// Directed plus randomized bench for fresh_range_engine, checked against a
// per-ID bitmap model that applies whole ranges in FIFO order.
module tb_fresh_range_engine;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rng_valid = 1'b0, rng_ready, rng_fresh = 1'b0;
    logic [7:0] rng_low = '0, rng_high = '0;
    logic       clr_req = 1'b0, chk_valid = 1'b0, chk_ready;
    logic [7:0] chk_addr = '0;
    logic       out_valid, out_fresh, busy, err_inverted;
    logic [15:0] ranges_done;
    logic [1:0]  dbg_state;

    fresh_range_engine #(.ADDR_W(8), .WORD_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .rng_valid(rng_valid), .rng_ready(rng_ready),
        .rng_low(rng_low), .rng_high(rng_high), .rng_fresh(rng_fresh),
        .clr_req(clr_req),
        .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_ready(chk_ready),
        .out_valid(out_valid), .out_fresh(out_fresh),
        .busy(busy), .err_inverted(err_inverted), .ranges_done(ranges_done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fill_cnt, clr_cnt;

    // Reference model: one bit per ID plus the ranges not yet known to be applied.
    bit          model_bm [256];
    logic [16:0] model_q [$];
    bit          model_err;
    int          model_done;

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model_bm[i] = 1'b0;
        model_err = 1'b0;
    endfunction

    function automatic void model_apply(input logic [16:0] e);
        int lo, hi;
        lo = int'(e[7:0]);
        hi = int'(e[15:8]);
        if (lo > hi) begin
            model_err = 1'b1;
        end else begin
            for (int i = lo; i <= hi; i++) model_bm[i] = e[16];
            model_done++;
        end
    endfunction

    function automatic void model_flush();
        while (model_q.size() > 0) model_apply(model_q.pop_front());
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int g;
        g = 0;
        fill_cnt = 0;
        clr_cnt = 0;
        while (busy && g < 5000) begin
            if (dbg_state == ST_FILL) fill_cnt++;
            if (dbg_state == ST_CLEAR) clr_cnt++;
            g++;
            @(negedge clk);
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic push_range(input logic [7:0] lo, input logic [7:0] hi, input logic fr,
                              output bit stalled);
        int g;
        g = 0;
        stalled = 1'b0;
        rng_low = lo;
        rng_high = hi;
        rng_fresh = fr;
        rng_valid = 1'b1;
        while (!rng_ready && g < 500) begin
            stalled = 1'b1;
            g++;
            @(negedge clk);
        end
        check("push_ready_timeout", {31'd0, rng_ready}, 32'd1);
        @(negedge clk);
        rng_valid = 1'b0;
        model_q.push_back({fr, hi, lo});
    endtask

    task automatic lookup(input logic [7:0] a, input logic exp, input string tag);
        chk_addr = a;
        chk_valid = 1'b1;
        check({tag, "_rdy"}, {31'd0, chk_ready}, 32'd1);
        @(negedge clk);
        chk_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(tag, {31'd0, out_fresh}, {31'd0, exp});
    endtask

    task automatic lookup_pair(input logic [7:0] a, input logic [7:0] b);
        chk_addr = a;
        chk_valid = 1'b1;
        @(negedge clk);
        chk_addr = b;
        check("pair_a_valid", {31'd0, out_valid}, 32'd1);
        check("pair_a", {31'd0, out_fresh}, {31'd0, model_bm[a]});
        @(negedge clk);
        chk_valid = 1'b0;
        check("pair_b_valid", {31'd0, out_valid}, 32'd1);
        check("pair_b", {31'd0, out_fresh}, {31'd0, model_bm[b]});
    endtask

    task automatic clr_pulse();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
    endtask

    task automatic reset_and_sweep(input string tag);
        int n, rdy;
        n = 0;
        rdy = 0;
        rst = 1'b0;
        rng_valid = 1'b0;
        chk_valid = 1'b0;
        clr_req = 1'b0;
        #1;
        check({tag, "_done0"}, {16'd0, ranges_done}, 32'd0);
        check({tag, "_err0"}, {31'd0, err_inverted}, 32'd0);
        check({tag, "_oval0"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ofr0"}, {31'd0, out_fresh}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        while (busy && n < 1000) begin
            n++;
            if (chk_ready) rdy++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, 32'd32);
        check({tag, "_rdy_during_sweep"}, rdy, 32'd0);
        model_clear();
        model_q.delete();
        model_done = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        bit stalls [5];
        logic [7:0] singles [5];
        logic [7:0] a, b, x;
        logic       old_v, fr40;

        // Scenario 1: reset sweep then a lookup of a cleared ID.
        @(negedge clk);
        reset_and_sweep("rst1");
        lookup(8'd5, 1'b0, "s1_lk5");
        @(negedge clk);
        check("s1_oval_pulse", {31'd0, out_valid}, 32'd0);
        check("s1_ofr_hold", {31'd0, out_fresh}, 32'd0);

        // Scenario 2: 3..20 fresh spans words 0..2.
        push_range(8'd3, 8'd20, 1'b1, st);
        wait_idle("s2");
        model_flush();
        check("s2_fill_cycles", fill_cnt, 32'd3);
        check("s2_done", {16'd0, ranges_done}, 32'd1);
        lookup(8'd2, 1'b0, "s2_lk2");
        lookup(8'd3, 1'b1, "s2_lk3");
        lookup(8'd20, 1'b1, "s2_lk20");
        lookup(8'd21, 1'b0, "s2_lk21");

        // Scenario 3: 10..12 spoiled overwrites the middle.
        push_range(8'd10, 8'd12, 1'b0, st);
        wait_idle("s3");
        model_flush();
        check("s3_done", {16'd0, ranges_done}, 32'd2);
        lookup(8'd9, 1'b1, "s3_lk9");
        for (int i = 10; i <= 12; i++) lookup(8'(i), 1'b0, "s3_lk_mid");
        lookup(8'd13, 1'b1, "s3_lk13");

        // Scenario 4: inverted range is dropped; a clear resets the sticky flag.
        push_range(8'd9, 8'd4, 1'b1, st);
        wait_idle("s4");
        model_flush();
        check("s4_err", {31'd0, err_inverted}, 32'd1);
        check("s4_done", {16'd0, ranges_done}, 32'd2);
        lookup(8'd5, model_bm[5], "s4_lk5");
        lookup(8'd4, 1'b1, "s4_lk4");
        clr_pulse();
        wait_idle("s4c");
        model_clear();
        check("s4_clr_cycles", clr_cnt, 32'd32);
        check("s4_err_cleared", {31'd0, err_inverted}, 32'd0);
        check("s4_done_kept", {16'd0, ranges_done}, 32'd2);
        lookup(8'd4, 1'b0, "s4_lk4_after_clr");

        // Scenario 5: full fill, then five singles back-to-back against a depth-4 FIFO.
        push_range(8'd0, 8'd255, 1'b1, st);
        for (int k = 0; k < 5; k++) begin
            singles[k] = 8'($urandom_range(0, 254));
            push_range(singles[k], singles[k], 1'($urandom_range(0, 1)), st);
            stalls[k] = st;
        end
        check("s5_first_no_stall", {31'd0, stalls[0]}, 32'd0);
        check("s5_fifth_stalled", {31'd0, stalls[4]}, 32'd1);
        wait_idle("s5");
        model_flush();
        check("s5_done", {16'd0, ranges_done}, model_done);
        lookup(8'd255, 1'b1, "s5_lk255");
        for (int k = 0; k < 5; k++) lookup(singles[k], model_bm[singles[k]], "s5_single");

        // Scenario 6: clear mid-fill with 40..40 queued behind.
        fr40 = 1'($urandom_range(0, 1));
        push_range(8'd0, 8'd255, 1'b1, st);
        push_range(8'd40, 8'd40, fr40, st);
        begin
            int g;
            g = 0;
            while (dbg_state != ST_FILL && g < 100) begin g++; @(negedge clk); end
            check("s6_fill_start", {30'd0, dbg_state}, {30'd0, ST_FILL});
        end
        repeat (4) @(negedge clk);
        clr_pulse();
        model_apply(model_q.pop_front());
        model_clear();
        wait_idle("s6");
        model_flush();
        check("s6_clr_cycles", clr_cnt, 32'd32);
        check("s6_done", {16'd0, ranges_done}, model_done);
        lookup(8'd0, 1'b0, "s6_lk0");
        lookup(8'd40, fr40, "s6_lk40");
        lookup(8'd255, 1'b0, "s6_lk255");

        // Lookup in the same cycle as a push sees the old contents.
        x = 8'($urandom_range(0, 255));
        old_v = model_bm[x];
        chk_addr = x;
        chk_valid = 1'b1;
        rng_low = x;
        rng_high = x;
        rng_fresh = ~old_v;
        rng_valid = 1'b1;
        @(negedge clk);
        chk_valid = 1'b0;
        rng_valid = 1'b0;
        model_q.push_back({~old_v, x, x});
        check("same_cycle_old", {31'd0, out_fresh}, {31'd0, old_v});
        check("same_cycle_rdy_drop", {31'd0, chk_ready}, 32'd0);
        wait_idle("same");
        model_flush();
        lookup(x, ~old_v, "same_cycle_new");

        // Randomized ranges, occasional clears while idle, back-to-back lookups.
        for (int it = 0; it < 15; it++) begin
            int nr;
            nr = $urandom_range(1, 3);
            for (int r = 0; r < nr; r++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0 && a > b) begin
                    x = a; a = b; b = x;
                end
                push_range(a, b, 1'($urandom_range(0, 1)), st);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_idle("rnd");
            model_flush();
            if ($urandom_range(0, 3) == 0) begin
                clr_pulse();
                wait_idle("rnd_clr");
                model_clear();
            end
            check("rnd_done", {16'd0, ranges_done}, model_done);
            check("rnd_err", {31'd0, err_inverted}, {31'd0, model_err});
            for (int l = 0; l < 3; l++)
                lookup_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Reset mid-fill abandons the range and flushes the FIFO.
        push_range(8'd0, 8'd255, 1'b1, st);
        push_range(8'd7, 8'd7, 1'b1, st);
        repeat (3) @(negedge clk);
        reset_and_sweep("rst2");
        check("rst2_idle_done", {16'd0, ranges_done}, 32'd0);
        lookup(8'd0, 1'b0, "rst2_lk0");
        lookup(8'd7, 1'b0, "rst2_lk7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
